// File: rtl/lsu_word_bus_pkg.sv
// Shared encodings for the load/store unit: access-size codes, the default
// data-segment base, FSM state type and the load extension helpers.
package lsu_word_bus_pkg;

    // Access size on req_op; 2'b00 is reserved and always rejected.
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;

    // Byte address of data-memory word 0.
    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h1001_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Widen a byte to 32 bits, sign-extending when sign = 1.
    function automatic logic [31:0] ext_8_32(input logic [7:0] b, input logic sign);
        return {{24{sign & b[7]}}, b};
    endfunction

    // Widen a half-word to 32 bits, sign-extending when sign = 1.
    function automatic logic [31:0] ext_16_32(input logic [15:0] h, input logic sign);
        return {{16{sign & h[15]}}, h};
    endfunction

endpackage

// File: rtl/lsu_word_bus_if.sv
// Signal bundle between the CPU memory stage, the load/store unit and the
// word-wide data-memory bus.
//
// Handshakes:
//   CPU side : a request transfers on a rising edge where req_valid && req_ready.
//              The unit answers with a single-cycle resp_valid pulse.
//   Bus side : mem_req is held high, with mem_we/mem_index/mem_wdata stable,
//              until a rising edge where mem_ack is high; mem_rdata is taken
//              on that edge. mem_ack is ignored while mem_req is low.
interface lsu_word_bus_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_op;
    logic              req_ext;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_index;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // The load/store unit: target of CPU requests, initiator on the bus.
    modport master (
        input  req_valid, req_we, req_op, req_ext, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_index, mem_wdata
    );

    // Environment: CPU stage plus data memory.
    modport slave (
        output req_valid, req_we, req_op, req_ext, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_index, mem_wdata
    );
endinterface

// File: rtl/lsu_word_bus_lane_extract.sv
// Read-side lane selection: picks the addressed byte/half out of a bus word
// and zero- or sign-extends it to 32 bits.
module lane_extract
    import lsu_word_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  op,
    input  logic        ext,
    output logic [31:0] result
);

    // Little-endian lane select followed by extension; word loads pass through.
    always_comb begin
        result = 32'd0;
        case (op)
            MEM_BYTE: result = ext_8_32(word[{lane, 3'b000} +: 8], ext);
            MEM_HALF: result = ext_16_32(lane[1] ? word[31:16] : word[15:0], ext);
            MEM_WORD: result = word;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_word_bus.sv
// Load/store unit: accepts one CPU access at a time, validates it against the
// data segment and turns it into word-wide bus reads/writes. Sub-word stores
// become read-modify-write; sub-word loads are lane-extracted and extended.
module lsu_word_bus
    import lsu_word_bus_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_ADDRESS,
    parameter int          ADDR_W    = 10
)(
    input  logic          clk,
    input  logic          rstn,
    lsu_word_bus_if.master bus,
    output lsu_state_e    state_dbg
);

    lsu_state_e        state, state_nxt;
    logic [31:0]       offset;
    logic [1:0]        lane_in;
    logic              range_bad, align_bad, req_bad, accept;
    logic              we_q, ext_q;
    logic [1:0]        op_q, lane_q;
    logic [ADDR_W-1:0] index_q;
    logic [31:0]       wdata_q, mem_wdata_q, merged, load_data;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    // Offset wraps modulo 2^32, so addresses below the base land far above
    // the segment and fail the range test.
    assign offset    = bus.req_addr - DATA_BASE;
    assign lane_in   = offset[1:0];
    assign range_bad = (offset >> (ADDR_W + 2)) != 32'd0;
    assign align_bad = (bus.req_op == 2'b00)
                    || (bus.req_op == MEM_HALF && lane_in[0])
                    || (bus.req_op == MEM_WORD && lane_in != 2'b00);
    assign req_bad   = range_bad || align_bad;
    assign accept    = bus.req_valid && (state == ST_IDLE);

    // State register; reset abandons any bus transaction immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: errors skip the bus, word stores skip the read phase.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (req_bad)                              state_nxt = ST_DONE;
                else if (bus.req_we && bus.req_op == MEM_WORD) state_nxt = ST_WR;
                else                                      state_nxt = ST_RD;
            end
            ST_RD:   if (bus.mem_ack) state_nxt = we_q ? ST_WR : ST_DONE;
            ST_WR:   if (bus.mem_ack) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs decoded purely from the state register.
    always_comb begin
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = (state == ST_DONE);
        bus.mem_req    = (state == ST_RD) || (state == ST_WR);
        bus.mem_we     = (state == ST_WR);
    end

    // Store merge: overlay the low store bits onto the word just read.
    always_comb begin
        merged = bus.mem_rdata;
        case (op_q)
            MEM_BYTE: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            MEM_HALF: if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                      else           merged[15:0]  = wdata_q[15:0];
            default:  merged = wdata_q;
        endcase
    end

    lane_extract u_lane_extract (
        .word   (bus.mem_rdata),
        .lane   (lane_q),
        .op     (op_q),
        .ext    (ext_q),
        .result (load_data)
    );

    // Request latch, bus write word and response registers. The response
    // registers change only on the way into DONE so they hold between responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q         <= 1'b0;
            ext_q        <= 1'b0;
            op_q         <= 2'b00;
            lane_q       <= 2'b00;
            index_q      <= '0;
            wdata_q      <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    we_q        <= bus.req_we;
                    ext_q       <= bus.req_ext;
                    op_q        <= bus.req_op;
                    lane_q      <= lane_in;
                    index_q     <= offset[ADDR_W+1:2];
                    wdata_q     <= bus.req_wdata;
                    mem_wdata_q <= bus.req_wdata;
                    if (req_bad) begin
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b1;
                    end
                end
                ST_RD: if (bus.mem_ack) begin
                    if (we_q) begin
                        mem_wdata_q <= merged;
                    end else begin
                        resp_rdata_q <= load_data;
                        resp_err_q   <= 1'b0;
                    end
                end
                ST_WR: if (bus.mem_ack) begin
                    resp_rdata_q <= 32'd0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_index  = index_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign state_dbg      = state;

endmodule
